// File: rtl/countdown_timer_pkg.sv
// Shared Genius game definitions: FSM state encoding and default window sizes.
package countdown_timer_pkg;

    // Response-window timer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } cdt_state_t;

    // Default counter width.
    localparam int CDT_SIZE = 4;

    // Default window length in ticks. This matches the up-counter range.
    localparam int CDT_WINDOW = 9;

endpackage

// File: rtl/countdown_timer.sv
// Down-counting response-window timer. START loads LIMIT, and each E tick
// decrements TEMPO. A HIT reloads the window. Expiry is reported as a one-cycle
// end_time pulse together with a level TIMEOUT.
import countdown_timer_pkg::*;

module countdown_timer #(
    parameter int SIZE = CDT_SIZE
) (
    input  logic            CLKT,
    input  logic            R,
    input  logic            START,
    input  logic            STOP,
    input  logic            HIT,
    input  logic            E,
    input  logic [SIZE-1:0] LIMIT,
    output logic [SIZE-1:0] TEMPO,
    output logic            end_time,
    output logic            TIMEOUT,
    output logic            RUNNING
);

    cdt_state_t      r_state;
    cdt_state_t      w_state_nxt;
    logic [SIZE-1:0] r_tempo;
    logic [SIZE-1:0] w_tempo_nxt;
    logic            r_end;
    logic            w_end_nxt;

    // Register state, counter and the expiry pulse. Reset overrides all other inputs.
    always_ff @(posedge CLKT) begin
        if (R) begin
            r_state <= ST_IDLE;
            r_tempo <= '0;
            r_end   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tempo <= w_tempo_nxt;
            r_end   <= w_end_nxt;
        end
    end

    // Next-state logic. Input priority is STOP > START > HIT > E.
    // A zero LIMIT on load expires immediately rather than running.
    always_comb begin
        w_state_nxt = r_state;
        w_tempo_nxt = r_tempo;
        w_end_nxt   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (STOP) begin
                    w_state_nxt = ST_IDLE;
                end else if (START || HIT) begin
                    w_tempo_nxt = LIMIT;
                    if (LIMIT == '0) begin
                        w_state_nxt = ST_EXPIRED;
                        w_end_nxt   = 1'b1;
                    end
                end else if (E) begin
                    if (r_tempo == SIZE'(1)) begin
                        w_tempo_nxt = '0;
                        w_state_nxt = ST_EXPIRED;
                        w_end_nxt   = 1'b1;
                    end else if (r_tempo > SIZE'(1)) begin
                        w_tempo_nxt = r_tempo - SIZE'(1);
                    end
                end
            end
            default: begin
                // IDLE and EXPIRED share this behaviour: HIT and E are ignored.
                if (STOP) begin
                    w_state_nxt = ST_IDLE;
                end else if (START) begin
                    w_tempo_nxt = LIMIT;
                    if (LIMIT == '0) begin
                        w_state_nxt = ST_EXPIRED;
                        w_end_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
        endcase
    end

    assign TEMPO    = r_tempo;
    assign end_time = r_end;
    assign TIMEOUT  = (r_state == ST_EXPIRED);
    assign RUNNING  = (r_state == ST_RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer. Each check compares the packed
// observation {TEMPO, end_time, TIMEOUT, RUNNING} against a hand-computed value.
module tb_countdown_timer;

    logic       CLKT = 1'b0;
    logic       R = 1'b0;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic       HIT = 1'b0;
    logic       E = 1'b0;
    logic [3:0] LIMIT = 4'd0;
    logic [3:0] TEMPO;
    logic       end_time;
    logic       TIMEOUT;
    logic       RUNNING;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_v;

    countdown_timer #(.SIZE(4)) dut (
        .CLKT(CLKT), .R(R), .START(START), .STOP(STOP), .HIT(HIT), .E(E),
        .LIMIT(LIMIT), .TEMPO(TEMPO), .end_time(end_time),
        .TIMEOUT(TIMEOUT), .RUNNING(RUNNING)
    );

    always #5 CLKT = ~CLKT;

    // Inputs change 1ns after the rising edge and are sampled at the next
    // rising edge. Outputs are read 1ns after that edge.
    task automatic cyc();
        @(posedge CLKT);
        #1;
    endtask

    task automatic clr_in();
        R = 1'b0; START = 1'b0; STOP = 1'b0; HIT = 1'b0; E = 1'b0;
    endtask

    task automatic test_reset();
        R = 1'b1; START = 1'b1; LIMIT = 4'd7; cyc(); clr_in();
        exp_v = {4'd0, 1'b0, 1'b0, 1'b0}; checks++;
        if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
            errors++; $display("FAIL reset: got %b want %b", {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
        end
    endtask

    task automatic test_countdown();
        LIMIT = 4'd3; START = 1'b1; cyc(); clr_in();
        exp_v = {4'd3, 1'b0, 1'b0, 1'b1}; checks++;
        if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
            errors++; $display("FAIL cd_load: got %b want %b", {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
        end
        for (int k = 1; k <= 3; k++) begin
            for (int g = 0; g < 3; g++) begin
                cyc();
                exp_v = {4'(4 - k), 1'b0, 1'b0, 1'b1}; checks++;
                if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
                    errors++; $display("FAIL cd_hold%0d: got %b want %b", k, {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
                end
            end
            E = 1'b1; cyc(); E = 1'b0;
            exp_v = (k == 3) ? {4'd0, 1'b1, 1'b1, 1'b0} : {4'(3 - k), 1'b0, 1'b0, 1'b1}; checks++;
            if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
                errors++; $display("FAIL cd_tick%0d: got %b want %b", k, {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
            end
        end
        cyc();
        exp_v = {4'd0, 1'b0, 1'b1, 1'b0}; checks++;
        if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
            errors++; $display("FAIL cd_pulse_once: got %b want %b", {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
        end
    endtask

    task automatic test_hit_reload();
        LIMIT = 4'd5; START = 1'b1; cyc(); clr_in();
        E = 1'b1; cyc(); cyc(); E = 1'b0;
        exp_v = {4'd3, 1'b0, 1'b0, 1'b1}; checks++;
        if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
            errors++; $display("FAIL hit_pre: got %b want %b", {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
        end
        HIT = 1'b1; cyc(); HIT = 1'b0;
        exp_v = {4'd5, 1'b0, 1'b0, 1'b1}; checks++;
        if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
            errors++; $display("FAIL hit_reload: got %b want %b", {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
        end
        E = 1'b1; cyc(); cyc(); cyc(); cyc(); E = 1'b0;
        exp_v = {4'd1, 1'b0, 1'b0, 1'b1}; checks++;
        if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
            errors++; $display("FAIL hit_at1: got %b want %b", {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
        end
        HIT = 1'b1; E = 1'b1; cyc(); clr_in();
        exp_v = {4'd5, 1'b0, 1'b0, 1'b1}; checks++;
        if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
            errors++; $display("FAIL hit_beats_e: got %b want %b", {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
        end
        LIMIT = 4'd7; STOP = 1'b1; START = 1'b1; cyc(); clr_in();
        exp_v = {4'd5, 1'b0, 1'b0, 1'b0}; checks++;
        if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
            errors++; $display("FAIL stop_beats_start: got %b want %b", {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
        end
        HIT = 1'b1; E = 1'b1; cyc(); clr_in();
        exp_v = {4'd5, 1'b0, 1'b0, 1'b0}; checks++;
        if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
            errors++; $display("FAIL idle_ignore: got %b want %b", {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
        end
    endtask

    task automatic test_zero_limit();
        LIMIT = 4'd0; START = 1'b1; cyc(); clr_in();
        exp_v = {4'd0, 1'b1, 1'b1, 1'b0}; checks++;
        if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
            errors++; $display("FAIL zero_limit: got %b want %b", {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
        end
        E = 1'b1; HIT = 1'b1; cyc(); clr_in();
        exp_v = {4'd0, 1'b0, 1'b1, 1'b0}; checks++;
        if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
            errors++; $display("FAIL exp_ignore: got %b want %b", {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
        end
        LIMIT = 4'd2; START = 1'b1; cyc(); clr_in();
        exp_v = {4'd2, 1'b0, 1'b0, 1'b1}; checks++;
        if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
            errors++; $display("FAIL exp_restart: got %b want %b", {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
        end
        LIMIT = 4'd0; HIT = 1'b1; cyc(); clr_in();
        exp_v = {4'd0, 1'b1, 1'b1, 1'b0}; checks++;
        if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
            errors++; $display("FAIL hit_zero: got %b want %b", {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
        end
        STOP = 1'b1; cyc(); clr_in();
        exp_v = {4'd0, 1'b0, 1'b0, 1'b0}; checks++;
        if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
            errors++; $display("FAIL exp_stop: got %b want %b", {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
        end
    endtask

    task automatic test_max_limit();
        LIMIT = 4'd15; START = 1'b1; cyc(); clr_in();
        E = 1'b1; cyc(); E = 1'b0;
        exp_v = {4'd14, 1'b0, 1'b0, 1'b1}; checks++;
        if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
            errors++; $display("FAIL max_limit: got %b want %b", {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        LIMIT = 4'd6; START = 1'b1; cyc(); clr_in();
        LIMIT = 4'd9; E = 1'b1; cyc(); cyc(); E = 1'b0;
        exp_v = {4'd4, 1'b0, 1'b0, 1'b1}; checks++;
        if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
            errors++; $display("FAIL limit_change: got %b want %b", {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
        end
        R = 1'b1; E = 1'b1; HIT = 1'b1; cyc(); clr_in();
        exp_v = {4'd0, 1'b0, 1'b0, 1'b0}; checks++;
        if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
            errors++; $display("FAIL reset_mid: got %b want %b", {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
        end
        E = 1'b1; cyc(); cyc(); cyc(); E = 1'b0;
        exp_v = {4'd0, 1'b0, 1'b0, 1'b0}; checks++;
        if ({TEMPO, end_time, TIMEOUT, RUNNING} !== exp_v) begin
            errors++; $display("FAIL post_reset_e: got %b want %b", {TEMPO, end_time, TIMEOUT, RUNNING}, exp_v);
        end
    endtask

    initial begin
        cyc();
        test_reset();
        test_countdown();
        test_hit_reload();
        test_zero_limit();
        test_max_limit();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting response-window timer for the Genius game datapath. It is the complement of the up-counting time counter.
- On START it loads a limit and counts down on each enable tick. It restarts the window on every player HIT.
- It flags expiry with a one-cycle end_time pulse and a level TIMEOUT.
- The game FSM uses it to bound how long the player may take to press each button of the sequence.

Parameters:
- SIZE, 4, width of the TEMPO and LIMIT counters.

Ports:
- CLKT  input  1  system clock; all logic on its rising edge.
- R  input  1  reset, synchronous, active-high.
- START  input  1  load LIMIT into TEMPO and begin (or restart) the countdown.
- STOP  input  1  abort the countdown and return to idle; TEMPO is held.
- HIT  input  1  player pressed a button; reloads the window while running.
- E  input  1  count-enable tick (one pulse per time unit from the prescaler).
- LIMIT  input  SIZE  window length in ticks; sampled only on START or HIT.
- TEMPO  output  SIZE  remaining ticks.
- end_time  output  1  one-cycle pulse on the cycle expiry is registered.
- TIMEOUT  output  1  level; high while in EXPIRED.
- RUNNING  output  1  level; high while in RUN.

Behaviour:
- Reset is synchronous: when R=1 at a CLKT edge, state=IDLE, TEMPO=0, end_time=0, TIMEOUT=0, RUNNING=0. R overrides all other inputs.
- State machine with states IDLE, RUN and EXPIRED. All outputs are registered; TIMEOUT and RUNNING are decoded from the registered state.
- Input priority within a cycle: R > STOP > START > HIT > E.
- IDLE:
  - START → TEMPO<=LIMIT. If LIMIT==0, go to EXPIRED with end_time=1; otherwise go to RUN.
  - HIT and E are ignored. STOP keeps the block in IDLE.
- RUN:
  - STOP → IDLE, TEMPO unchanged.
  - START or HIT → TEMPO<=LIMIT, stay in RUN. If LIMIT==0, go to EXPIRED with end_time=1.
  - E with TEMPO==1 → TEMPO<=0, end_time=1, go to EXPIRED.
  - E with TEMPO>1 → TEMPO<=TEMPO-1.
  - Otherwise hold.
- EXPIRED:
  - TEMPO stays 0 and TIMEOUT=1.
  - START reloads exactly as from IDLE. STOP → IDLE.
  - HIT and E are ignored.
- end_time:
  - High for exactly one cycle per expiry: the cycle after the expiring edge, coincident with the first TIMEOUT=1 cycle.
  - Low in every other cycle, including cycles where STOP or reset occurs.
- Arithmetic: the decrement is SIZE bits and never wraps. TEMPO==0 is never decremented in RUN.
- Boundary conditions:
  - HIT together with E while TEMPO==1: HIT wins, the window reloads, no expiry.
  - START together with STOP: STOP wins.
  - Reset mid-countdown: returns to IDLE next edge with TEMPO=0 and no end_time pulse.
  - LIMIT changing while RUN: no effect until the next START or HIT.
  - Maximum LIMIT is 2^SIZE-1 (15 at the default).

Decomposition:
- Shared game package holds:
  - the state typedef (IDLE, RUN, EXPIRED);
  - the default SIZE constant;
  - the default window constant (9 ticks, matching the up-counter range).
- No sub-module. The tick prescaler that drives E already exists upstream; the block stays a single FSM-plus-counter module.

Test Plan:
- R=1 then release; START with LIMIT=3; E pulsed every 4 cycles → TEMPO goes 3,2,1,0. end_time is high for exactly one cycle on the 3rd E. TIMEOUT=1 and RUNNING=0 afterwards.
- LIMIT=5, START, two E pulses (TEMPO=3), then HIT → TEMPO=5, RUNNING stays 1, no end_time pulse.
- TEMPO=1 in RUN, HIT and E asserted in the same cycle → TEMPO=5, no expiry. STOP and START in the same cycle → IDLE, TEMPO held.
- START with LIMIT=0 → next cycle TIMEOUT=1, end_time=1 for one cycle, TEMPO=0.
- In EXPIRED, assert E and HIT → no change. START with LIMIT=2 → RUN, TEMPO=2, TIMEOUT=0.
- In RUN with TEMPO=4, assert R → next edge IDLE, TEMPO=0, all flags 0. Further E pulses → TEMPO stays 0.
